video_nmode_sched: RTL and testbench
====================================

Name: video_nmode_sched

Overview:
- Sequences all DRAM video fetches for the new videomode (mode #4).
- At frame start it fetches the 256-word palette. At each visible line start it fetches a 4-word line descriptor, then runs the plane 0/plane 1 pixel fetches for the rest of the line.
- It drives the fetch-type selects and pointer registers consumed by the video address generator, plus the fetch bandwidth request toward the DRAM arbiter.

Parameters:
- PAL_WORDS, 256, palette words fetched per frame
- DESC_WORDS, 4, descriptor words per line
- LINES, 200, visible lines with descriptors
- PIX_WORDS, 160, pixel-fetch slots per line (both planes together)
- DESC_BASE, 256, nfetch_ptr offset of descriptor table

Ports:
- clk  in  1  28 MHz clock
- rst_n  in  1  asynchronous active-low reset
- mode_new  in  1  new videomode enabled
- int_start  in  1  frame start strobe
- line_start  in  1  line start strobe
- vpix  in  1  visible line
- video_next  in  1  arbiter accepted current address
- video_strobe  in  1  video_data valid
- video_data  in  16  fetched word
- naddr_fetch  out  1  select palette/descriptor address
- naddr_plane0  out  1  select plane 0 address
- naddr_plane1  out  1  select plane 1 address
- nfetch_ptr  out  11  palette/descriptor word pointer
- nyptr0, nyptr1  out  13 each  plane Y pointers
- nxctr0, nxctr1  out  8 each  plane X counters
- lmode  out  2  line mode: 00 320_64C, 01 640_16C, 10 320_DPF, 11 640_TXT
- pal54  out  2  palette bits 5:4
- scrleft  out  3  left scroll
- plane1_lag  out  2  DPF plane 1 lag
- video_bw  out  2  requested bandwidth; 11 during PAL/DESC, 00 in IDLE, otherwise per lmode
- pal_we  out  1  palette write pulse
- pal_addr  out  8  palette write address
- pal_data  out  16  palette write data
- overrun  out  1  sticky: line ended with fetch incomplete

Behaviour:
- Reset: all outputs 0; state IDLE; line counter 0.
- FSM states: IDLE, PAL, DESC, PIX, DONE.
- int_start with mode_new=1, from any state:
  - go PAL; nfetch_ptr=0; pal_addr=0; line counter=0.
  - clears overrun. When int_start and line_start coincide, int_start wins.
- PAL:
  - naddr_fetch=1.
  - nfetch_ptr increments on each video_next.
  - Each video_strobe gives pal_we=1 the same cycle: pal_data=video_data, pal_addr=strobe index; pal_addr increments after the write.
  - After the 256th strobe: go IDLE, or DESC if a line_start is pending.
- Line start:
  - Qualified as line_start & vpix & mode_new & (line counter < LINES).
  - In PAL: latched as pending.
  - In PIX with fewer than PIX_WORDS slots issued: set overrun, abort, go DESC.
- DESC entry: nfetch_ptr = DESC_BASE + 4*line.
- DESC:
  - naddr_fetch=1; nfetch_ptr increments on video_next.
  - The k-th strobe (k=0..3) loads registers; outputs update the cycle after the strobe:
    - w0: nyptr0=[12:0], lmode=[14:13]
    - w1: nyptr1=[12:0]
    - w2: nxctr0=[7:0], scrleft=[10:8], plane1_lag=[12:11], pal54=[14:13]
    - w3: nxctr1=[7:0]
  - After 4th strobe: line counter+1, go PIX.
- PIX:
  - Single-plane lmodes (00, 01): naddr_plane0=1 always.
  - Dual-plane lmodes (10, 11): plane0/plane1 alternate, starting at plane0, swapping on each video_next.
  - Each video_next increments the selected plane's nxctr, 8-bit wrap 255->0; nyptr is unchanged.
  - After PIX_WORDS video_next: go DONE (all selects 0).
- DONE: wait; the next qualified line_start goes to DESC.
- Exactly one of the naddr_* selects is high in PAL/DESC/PIX; none in IDLE/DONE.
- mode_new=0: go IDLE next cycle, selects 0, pointer registers hold.
- Strobes outside PAL/DESC are ignored by this block.
- Line counter reaching LINES: no further DESC until int_start.

Decomposition:
- Shared package holds:
  - LMODE_* codes
  - state encoding
  - descriptor bit-field positions
  - PAL_WORDS/DESC_WORDS/DESC_BASE
- One natural sub-module: video_ndesc_latch, which decodes descriptor words into pointer registers by strobe index.

Test Plan:
- Reset, then int_start, then 256 next/strobe pairs with data=index → 256 pal_we pulses, pal_addr 0..255, nfetch_ptr ends 256, state IDLE.
- line_start+vpix at line 0, descriptor words 0x2123/0x0456/0x5A10/0x0020 → nyptr0=0x0123, lmode=01, nyptr1=0x0456, nxctr0=0x10, scrleft=2, plane1_lag=3, pal54=2, nxctr1=0x20; nfetch_ptr started 256.
- lmode=10, nxctr0=0xFE, nxctr1=0x00, 160 video_next → selects alternate 0/1 starting plane0; nxctr0 wraps to 0x4E, nxctr1=0x50; then DONE.
- line_start after 100 of 160 PIX slots → overrun=1, DESC re-entered with nfetch_ptr=256+4*line.
- line_start during PAL at strobe 100 → DESC begins right after 256th strobe.
- 201 qualified line_starts → only 200 DESC entries; int_start clears line counter and overrun; rst_n low mid-PIX zeroes all outputs immediately.

Source files
------------

// File: rtl/video_nmode_sched_pkg.sv
// Shared constants, state encoding and descriptor field layout for the mode #4 fetch scheduler.
package video_nmode_sched_pkg;

    localparam int unsigned PAL_WORDS  = 256;
    localparam int unsigned DESC_WORDS = 4;
    localparam int unsigned LINES      = 200;
    localparam int unsigned PIX_WORDS  = 160;
    localparam int unsigned DESC_BASE  = 256;

    localparam logic [1:0] LMODE_320_64C = 2'b00;
    localparam logic [1:0] LMODE_640_16C = 2'b01;
    localparam logic [1:0] LMODE_320_DPF = 2'b10;
    localparam logic [1:0] LMODE_640_TXT = 2'b11;

    typedef enum logic [2:0] {
        StIdle,
        StPal,
        StDesc,
        StPix,
        StDone
    } state_e;

    // Descriptor word bit-field positions
    localparam int unsigned DESC_YPTR_LSB  = 0;
    localparam int unsigned DESC_LMODE_LSB = 13;
    localparam int unsigned DESC_XCTR_LSB  = 0;
    localparam int unsigned DESC_SCRL_LSB  = 8;
    localparam int unsigned DESC_LAG_LSB   = 11;
    localparam int unsigned DESC_PAL54_LSB = 13;

    function automatic logic lmode_dual(input logic [1:0] lm);
        return (lm == LMODE_320_DPF) || (lm == LMODE_640_TXT);
    endfunction

    // Text mode fetches less per slot than the bitmap modes
    function automatic logic [1:0] lmode_bw(input logic [1:0] lm);
        return (lm == LMODE_640_TXT) ? 2'b01 : 2'b10;
    endfunction

endpackage

// File: rtl/video_ndesc_latch.sv
// Decodes line-descriptor words into plane pointers and line attributes by strobe index;
// also advances the X counters as pixel slots are issued.
module video_ndesc_latch
    import video_nmode_sched_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        load,
    input  logic [1:0]  idx,
    input  logic [15:0] data,
    input  logic        inc0,
    input  logic        inc1,
    output logic [12:0] nyptr0,
    output logic [12:0] nyptr1,
    output logic [7:0]  nxctr0,
    output logic [7:0]  nxctr1,
    output logic [1:0]  lmode,
    output logic [1:0]  pal54,
    output logic [2:0]  scrleft,
    output logic [1:0]  plane1_lag
);

    logic unused_data_msb;
    assign unused_data_msb = data[15];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            nyptr0     <= '0;
            nyptr1     <= '0;
            nxctr0     <= '0;
            nxctr1     <= '0;
            lmode      <= '0;
            pal54      <= '0;
            scrleft    <= '0;
            plane1_lag <= '0;
        end else if (load) begin
            unique case (idx)
                2'd0: begin
                    nyptr0 <= data[DESC_YPTR_LSB +: 13];
                    lmode  <= data[DESC_LMODE_LSB +: 2];
                end
                2'd1: nyptr1 <= data[DESC_YPTR_LSB +: 13];
                2'd2: begin
                    nxctr0     <= data[DESC_XCTR_LSB +: 8];
                    scrleft    <= data[DESC_SCRL_LSB +: 3];
                    plane1_lag <= data[DESC_LAG_LSB +: 2];
                    pal54      <= data[DESC_PAL54_LSB +: 2];
                end
                2'd3: nxctr1 <= data[DESC_XCTR_LSB +: 8];
                default: ;
            endcase
        end else begin
            if (inc0) nxctr0 <= nxctr0 + 8'd1;
            if (inc1) nxctr1 <= nxctr1 + 8'd1;
        end
    end

endmodule

// File: rtl/video_nmode_sched.sv
// Mode #4 video fetch scheduler: palette per frame, descriptor per line, then plane pixel slots.
module video_nmode_sched
    import video_nmode_sched_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        mode_new,
    input  logic        int_start,
    input  logic        line_start,
    input  logic        vpix,
    input  logic        video_next,
    input  logic        video_strobe,
    input  logic [15:0] video_data,
    output logic        naddr_fetch,
    output logic        naddr_plane0,
    output logic        naddr_plane1,
    output logic [10:0] nfetch_ptr,
    output logic [12:0] nyptr0,
    output logic [12:0] nyptr1,
    output logic [7:0]  nxctr0,
    output logic [7:0]  nxctr1,
    output logic [1:0]  lmode,
    output logic [1:0]  pal54,
    output logic [2:0]  scrleft,
    output logic [1:0]  plane1_lag,
    output logic [1:0]  video_bw,
    output logic        pal_we,
    output logic [7:0]  pal_addr,
    output logic [15:0] pal_data,
    output logic        overrun
);

    state_e     state, state_next;
    logic [7:0] line_cnt;
    logic [7:0] pix_cnt;
    logic [1:0] desc_idx;
    logic       plane_sel;
    logic       line_pend;
    logic       dual;
    logic       frame_go, line_ok;
    logic       pal_last, desc_last, pix_last;
    logic       desc_enter, pix_enter;
    logic       desc_load, inc0, inc1;

    assign dual      = lmode_dual(lmode);
    assign frame_go  = int_start & mode_new;
    assign line_ok   = line_start & vpix & mode_new & (line_cnt < 8'(LINES));
    assign pal_last  = (state == StPal) & video_strobe & (pal_addr == 8'(PAL_WORDS - 1));
    assign desc_last = (state == StDesc) & video_strobe & (desc_idx == 2'(DESC_WORDS - 1));
    assign pix_last  = (state == StPix) & video_next & (pix_cnt == 8'(PIX_WORDS - 1));

    assign desc_enter = (state_next == StDesc) & (state != StDesc);
    assign pix_enter  = (state == StDesc) & (state_next == StPix);
    assign desc_load  = (state == StDesc) & video_strobe;
    assign inc0       = (state == StPix) & video_next & naddr_plane0;
    assign inc1       = (state == StPix) & video_next & naddr_plane1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= StIdle;
        else        state <= state_next;
    end

    always_comb begin
        state_next = state;
        if (!mode_new) begin
            state_next = StIdle;
        end else if (int_start) begin
            state_next = StPal;
        end else begin
            unique case (state)
                StIdle, StDone: if (line_ok) state_next = StDesc;
                StPal:  if (pal_last) state_next = (line_pend | line_ok) ? StDesc : StIdle;
                StDesc: if (desc_last) state_next = StPix;
                // A line start while slots remain aborts the line
                StPix: begin
                    if (line_ok)       state_next = StDesc;
                    else if (pix_last) state_next = StDone;
                end
                default: state_next = StIdle;
            endcase
        end
    end

    always_comb begin
        naddr_fetch  = 1'b0;
        naddr_plane0 = 1'b0;
        naddr_plane1 = 1'b0;
        video_bw     = 2'b00;
        pal_we       = 1'b0;
        pal_data     = '0;
        unique case (state)
            StPal: begin
                naddr_fetch = 1'b1;
                video_bw    = 2'b11;
                pal_we      = video_strobe;
                pal_data    = video_strobe ? video_data : 16'h0000;
            end
            StDesc: begin
                naddr_fetch = 1'b1;
                video_bw    = 2'b11;
            end
            StPix: begin
                naddr_plane0 = ~(dual & plane_sel);
                naddr_plane1 = dual & plane_sel;
                video_bw     = lmode_bw(lmode);
            end
            StDone:  video_bw = lmode_bw(lmode);
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            nfetch_ptr <= '0;
            pal_addr   <= '0;
            line_cnt   <= '0;
            desc_idx   <= '0;
            pix_cnt    <= '0;
            plane_sel  <= 1'b0;
            line_pend  <= 1'b0;
            overrun    <= 1'b0;
        end else if (frame_go) begin
            nfetch_ptr <= '0;
            pal_addr   <= '0;
            line_cnt   <= '0;
            line_pend  <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            if (desc_enter) begin
                nfetch_ptr <= 11'(DESC_BASE) + {1'b0, line_cnt, 2'b00};
                desc_idx   <= '0;
            end else begin
                if (naddr_fetch && video_next) nfetch_ptr <= nfetch_ptr + 11'd1;
                if (desc_load) desc_idx <= desc_idx + 2'd1;
            end
            if (pal_we) pal_addr <= pal_addr + 8'd1;
            line_pend <= (state == StPal) & ~pal_last & (line_pend | line_ok);
            if (pix_enter) begin
                line_cnt  <= line_cnt + 8'd1;
                pix_cnt   <= '0;
                plane_sel <= 1'b0;
            end else if (state == StPix && video_next) begin
                pix_cnt   <= pix_cnt + 8'd1;
                plane_sel <= dual & ~plane_sel;
            end
            if (state == StPix && state_next == StDesc) overrun <= 1'b1;
        end
    end

    video_ndesc_latch u_desc (
        .clk        (clk),
        .rst_n      (rst_n),
        .load       (desc_load),
        .idx        (desc_idx),
        .data       (video_data),
        .inc0       (inc0),
        .inc1       (inc1),
        .nyptr0     (nyptr0),
        .nyptr1     (nyptr1),
        .nxctr0     (nxctr0),
        .nxctr1     (nxctr1),
        .lmode      (lmode),
        .pal54      (pal54),
        .scrleft    (scrleft),
        .plane1_lag (plane1_lag)
    );

endmodule

// File: tb/tb_video_nmode_sched.sv
// Randomised bench for video_nmode_sched with a transaction-level reference model.
module tb_video_nmode_sched;

    logic        clk = 1'b0, rst_n = 1'b0, mode_new = 1'b0, int_start = 1'b0;
    logic        line_start = 1'b0, vpix = 1'b0, video_next = 1'b0, video_strobe = 1'b0;
    logic [15:0] video_data = '0;
    logic        naddr_fetch, naddr_plane0, naddr_plane1, pal_we, overrun;
    logic [10:0] nfetch_ptr;
    logic [12:0] nyptr0, nyptr1;
    logic [7:0]  nxctr0, nxctr1, pal_addr;
    logic [1:0]  lmode, pal54, plane1_lag, video_bw;
    logic [2:0]  scrleft;
    logic [15:0] pal_data;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model state
    int          lines_done;
    logic [15:0] pal_mem [256];
    logic [12:0] e_y0, e_y1;
    logic [7:0]  e_x0, e_x1;
    logic [1:0]  e_lm, e_p54, e_lag;
    logic [2:0]  e_scr;

    video_nmode_sched dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .mode_new     (mode_new),
        .int_start    (int_start),
        .line_start   (line_start),
        .vpix         (vpix),
        .video_next   (video_next),
        .video_strobe (video_strobe),
        .video_data   (video_data),
        .naddr_fetch  (naddr_fetch),
        .naddr_plane0 (naddr_plane0),
        .naddr_plane1 (naddr_plane1),
        .nfetch_ptr   (nfetch_ptr),
        .nyptr0       (nyptr0),
        .nyptr1       (nyptr1),
        .nxctr0       (nxctr0),
        .nxctr1       (nxctr1),
        .lmode        (lmode),
        .pal54        (pal54),
        .scrleft      (scrleft),
        .plane1_lag   (plane1_lag),
        .video_bw     (video_bw),
        .pal_we       (pal_we),
        .pal_addr     (pal_addr),
        .pal_data     (pal_data),
        .overrun      (overrun)
    );

    always #18 clk = ~clk;

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation did not complete, got timeout required finish");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h required 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic any_out();
        return |{naddr_fetch, naddr_plane0, naddr_plane1, nfetch_ptr, nyptr0, nyptr1, nxctr0,
                 nxctr1, lmode, pal54, scrleft, plane1_lag, video_bw, pal_we, pal_addr,
                 pal_data, overrun};
    endfunction

    task automatic frame_start();
        int_start = 1'b1;
        step();
        int_start  = 1'b0;
        lines_done = 0;
        check("frame_fetch_sel", 32'(naddr_fetch), 32'd1);
        check("frame_ptr", 32'(nfetch_ptr), 32'd0);
        check("frame_pal_addr", 32'(pal_addr), 32'd0);
        check("frame_overrun", 32'(overrun), 32'd0);
        check("frame_bw", 32'(video_bw), 32'd3);
    endtask

    task automatic pal_load(input int ls_at, input bit rnd);
        int bad = 0;
        int we_cnt = 0;
        for (int i = 0; i < 256; i++) begin
            pal_mem[i] = rnd ? 16'($urandom) : 16'(i);
            repeat ($urandom_range(0, 2)) begin
                @(negedge clk);
                if (pal_we) we_cnt++;
                step();
            end
            video_next   = 1'b1;
            video_strobe = 1'b1;
            video_data   = pal_mem[i];
            if (i == ls_at) begin
                line_start = 1'b1;
                vpix       = 1'b1;
            end
            @(negedge clk);
            if (pal_we) we_cnt++;
            if (pal_we !== 1'b1 || pal_addr !== 8'(i) || pal_data !== pal_mem[i]) bad++;
            step();
            video_next   = 1'b0;
            video_strobe = 1'b0;
            line_start   = 1'b0;
            vpix         = 1'b0;
        end
        check("pal_write_seq_bad", 32'(bad), 32'd0);
        check("pal_we_pulses", 32'(we_cnt), 32'd256);
        if (ls_at < 0) begin
            check("pal_end_ptr", 32'(nfetch_ptr), 32'd256);
            check("pal_end_idle_sel", 32'(naddr_fetch), 32'd0);
            check("pal_end_idle_bw", 32'(video_bw), 32'd0);
        end else begin
            check("pal_pend_desc_sel", 32'(naddr_fetch), 32'd1);
            check("pal_pend_desc_ptr", 32'(nfetch_ptr), 32'(256 + 4 * lines_done));
        end
    endtask

    task automatic line_go();
        line_start = 1'b1;
        vpix       = 1'b1;
        step();
        line_start = 1'b0;
        vpix       = 1'b0;
    endtask

    task automatic desc_load(input logic [15:0] w0, input logic [15:0] w1,
                             input logic [15:0] w2, input logic [15:0] w3);
        logic [15:0] w [4];
        int base;
        w[0] = w0; w[1] = w1; w[2] = w2; w[3] = w3;
        base = 256 + 4 * lines_done;
        check("desc_entry_sel", 32'(naddr_fetch), 32'd1);
        check("desc_entry_ptr", 32'(nfetch_ptr), 32'(base));
        check("desc_bw", 32'(video_bw), 32'd3);
        for (int k = 0; k < 4; k++) begin
            repeat ($urandom_range(0, 2)) step();
            video_next   = 1'b1;
            video_strobe = 1'b1;
            video_data   = w[k];
            step();
            video_next   = 1'b0;
            video_strobe = 1'b0;
        end
        lines_done++;
        e_y0 = w0[12:0];  e_lm  = w0[14:13];
        e_y1 = w1[12:0];
        e_x0 = w2[7:0];   e_scr = w2[10:8]; e_lag = w2[12:11]; e_p54 = w2[14:13];
        e_x1 = w3[7:0];
        check("desc_nyptr0", 32'(nyptr0), 32'(e_y0));
        check("desc_lmode", 32'(lmode), 32'(e_lm));
        check("desc_nyptr1", 32'(nyptr1), 32'(e_y1));
        check("desc_nxctr0", 32'(nxctr0), 32'(e_x0));
        check("desc_scrleft", 32'(scrleft), 32'(e_scr));
        check("desc_plane1_lag", 32'(plane1_lag), 32'(e_lag));
        check("desc_pal54", 32'(pal54), 32'(e_p54));
        check("desc_nxctr1", 32'(nxctr1), 32'(e_x1));
        check("desc_end_ptr", 32'(nfetch_ptr), 32'(base + 4));
        check("pix_first_plane0", 32'(naddr_plane0), 32'd1);
    endtask

    task automatic pix_run(input int n);
        int  bad = 0;
        int  c0 = 0;
        int  c1 = 0;
        bit  dual;
        bit  want1;
        dual = (e_lm == 2'b10) || (e_lm == 2'b11);
        for (int i = 0; i < n; i++) begin
            repeat ($urandom_range(0, 2)) step();
            want1 = dual && (i % 2 == 1);
            if (naddr_plane1 !== want1 || naddr_plane0 !== !want1 || naddr_fetch !== 1'b0) bad++;
            if (want1) c1++;
            else       c0++;
            video_next = 1'b1;
            step();
            video_next = 1'b0;
        end
        e_x0 = 8'((int'(e_x0) + c0) % 256);
        e_x1 = 8'((int'(e_x1) + c1) % 256);
        check("pix_select_seq_bad", 32'(bad), 32'd0);
        check("pix_nxctr0", 32'(nxctr0), 32'(e_x0));
        check("pix_nxctr1", 32'(nxctr1), 32'(e_x1));
        check("pix_nyptr0_hold", 32'(nyptr0), 32'(e_y0));
        if (n == 160) begin
            check("done_selects", 32'({naddr_fetch, naddr_plane0, naddr_plane1}), 32'd0);
        end
    endtask

    task automatic desc_quick();
        for (int k = 0; k < 4; k++) begin
            video_next   = 1'b1;
            video_strobe = 1'b1;
            video_data   = 16'($urandom);
            step();
        end
        video_next   = 1'b0;
        video_strobe = 1'b0;
        lines_done++;
    endtask

    initial begin
        int entries;
        int bad;
        #5;
        check("reset_outputs_zero", 32'(any_out()), 32'd0);
        repeat (2) step();
        rst_n    = 1'b1;
        mode_new = 1'b1;
        step();
        check("idle_after_reset", 32'(naddr_fetch | naddr_plane0 | naddr_plane1), 32'd0);

        // Frame 1: palette with data=index, then directed lines
        frame_start();
        pal_load(-1, 1'b0);
        line_go();
        desc_load(16'h2123, 16'h0456, 16'h5A10, 16'h0020);
        check("plan_nyptr0", 32'(nyptr0), 32'h0123);
        check("plan_scrleft", 32'(scrleft), 32'd2);
        pix_run(160);

        line_go();
        desc_load(16'h4000 | 16'($urandom_range(0, 8191)), 16'($urandom), 16'h00FE, 16'h0000);
        pix_run(160);
        check("dpf_wrap_nxctr0", 32'(nxctr0), 32'h4E);
        check("dpf_nxctr1", 32'(nxctr1), 32'h50);

        // Abort a line part-way through its pixel slots
        line_go();
        desc_load(16'($urandom), 16'($urandom), 16'($urandom), 16'($urandom));
        pix_run(100);
        check("no_overrun_yet", 32'(overrun), 32'd0);
        line_go();
        check("overrun_set", 32'(overrun), 32'd1);
        desc_load(16'($urandom), 16'($urandom), 16'($urandom), 16'($urandom));
        pix_run(160);

        for (int r = 0; r < 3; r++) begin
            line_go();
            desc_load(16'($urandom), 16'($urandom), 16'($urandom), 16'($urandom));
            pix_run(160);
        end
        check("overrun_sticky", 32'(overrun), 32'd1);

        // Mode off: selects drop, pointers hold
        line_go();
        desc_load(16'($urandom), 16'($urandom), 16'($urandom), 16'($urandom));
        pix_run(7);
        mode_new = 1'b0;
        step();
        check("mode_off_selects", 32'({naddr_fetch, naddr_plane0, naddr_plane1}), 32'd0);
        check("mode_off_bw", 32'(video_bw), 32'd0);
        check("mode_off_nxctr0_hold", 32'(nxctr0), 32'(e_x0));
        check("mode_off_nyptr1_hold", 32'(nyptr1), 32'(e_y1));
        mode_new = 1'b1;

        // Frame 2: line start pending during palette
        frame_start();
        pal_load(100, 1'b1);
        desc_load(16'($urandom), 16'($urandom), 16'($urandom), 16'($urandom));
        pix_run(160);

        // Frame 3: line limit
        frame_start();
        pal_load(-1, 1'b1);
        entries = 0;
        bad     = 0;
        for (int l = 0; l < 201; l++) begin
            line_go();
            if (naddr_fetch) begin
                entries++;
                if (nfetch_ptr !== 11'(256 + 4 * lines_done)) bad++;
                desc_quick();
            end
        end
        check("line_limit_entries", 32'(entries), 32'd200);
        check("line_limit_ptr_bad", 32'(bad), 32'd0);
        check("line_limit_overrun", 32'(overrun), 32'd1);

        // Frame 4: int_start clears line counter and overrun
        frame_start();
        pal_load(-1, 1'b1);
        line_go();
        desc_load(16'h4000 | 16'($urandom_range(0, 8191)), 16'($urandom), 16'($urandom),
                  16'($urandom));
        pix_run(30);
        check("pix_active_before_reset", 32'(naddr_plane0 | naddr_plane1), 32'd1);
        rst_n = 1'b0;
        #2;
        check("async_reset_outputs_zero", 32'(any_out()), 32'd0);
        step();
        rst_n = 1'b1;

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
